e_muldiv_ctrl: RTL and testbench

E_MULDIV_CTRL -- requirements
Module: e_muldiv_ctrl

---
 rtl/e_muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_e_muldiv_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv_ctrl.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers and pipeline stall control.
// Signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN; otherwise every operation is unsigned.
module e_muldiv_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_con_start,
  input  logic [1:0]  i_con_mdop,
  input  logic [31:0] i_data_rs,
  input  logic [31:0] i_data_rt,
  input  logic        i_con_flush,
  input  logic        i_con_hiloread,
  output logic        o_con_busy,
  output logic        o_con_stall,
  output logic        o_con_done,
  output logic        o_con_divzero,
  output logic [31:0] o_data_hi,
  output logic [31:0] o_data_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        divzero_q, divzero_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = i_con_mdop[0];
`else
  logic unused_mdop0;
  assign unused_mdop0 = i_con_mdop[0];
  assign signed_op    = 1'b0;
`endif

  always_comb begin
    a_mag = (signed_op && i_data_rs[31]) ? (~i_data_rs + 32'd1) : i_data_rs;
    b_mag = (signed_op && i_data_rt[31]) ? (~i_data_rt + 32'd1) : i_data_rt;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = (div_shift >= {1'b0, b_q}) ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                           : {div_shift[31:0], acc_q[30:0], 1'b0};

    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_d       = b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_con_start) begin
          div_d     = i_con_mdop[1];
          neg_res_d = signed_op & (i_data_rs[31] ^ i_data_rt[31]);
          neg_rem_d = signed_op & i_data_rs[31];
          acc_d     = {32'd0, a_mag};
          b_d       = b_mag;
          cnt_d     = 5'd0;
          if (i_con_mdop[1] && (i_data_rt == 32'd0)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            divzero_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // flush wins over both launch and completion; partial results are dropped
    if (i_con_flush) begin
      state_d   = S_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign o_con_busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign o_con_stall   = i_con_hiloread & o_con_busy;
  assign o_con_done    = done_q;
  assign o_con_divzero = divzero_q;
  assign o_data_hi     = hi_q;
  assign o_data_lo     = lo_q;

endmodule

// File: tb/tb_e_muldiv_ctrl.sv
// Self-checking bench for e_muldiv_ctrl: directed vectors, multi-cycle corner sequences
// and randomized operations against an arithmetic reference model.
module tb_e_muldiv_ctrl;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_con_start = 1'b0;
  logic [1:0]  i_con_mdop = 2'b00;
  logic [31:0] i_data_rs = 32'd0;
  logic [31:0] i_data_rt = 32'd0;
  logic        i_con_flush = 1'b0;
  logic        i_con_hiloread = 1'b0;
  logic        o_con_busy, o_con_stall, o_con_done, o_con_divzero;
  logic [31:0] o_data_hi, o_data_lo;

  e_muldiv_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_con_start(i_con_start), .i_con_mdop(i_con_mdop),
    .i_data_rs(i_data_rs), .i_data_rt(i_data_rt), .i_con_flush(i_con_flush),
    .i_con_hiloread(i_con_hiloread), .o_con_busy(o_con_busy), .o_con_stall(o_con_stall),
    .o_con_done(o_con_done), .o_con_divzero(o_con_divzero),
    .o_data_hi(o_data_hi), .o_data_lo(o_data_lo)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sh_hi = 32'd0;
  logic [31:0] sh_lo = 32'd0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic [31:0] hi_u, lo_u, hi_s, lo_s;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb;
    logic [63:0] p;
    hi = sh_hi; lo = sh_lo; dz = 1'b0;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    if (!op[1]) begin
      if (SIGNED && op[0]) p = sa * sb;
      else                 p = {32'd0, rs} * {32'd0, rt};
      hi = p[63:32]; lo = p[31:0];
    end else if (rt == 32'd0) begin
      dz = 1'b1;
    end else if (SIGNED && op[0]) begin
      p = sa / sb; lo = p[31:0];
      p = sa % sb; hi = p[31:0];
    end else begin
      lo = rs / rt; hi = rs % rt;
    end
  endfunction

  // Launch in the current cycle (cycle 0) and follow the operation to its done pulse.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit edz, input bit restart);
    int lat;
    int busy_bad;
    busy_bad = 0;
    i_con_mdop = op; i_data_rs = rs; i_data_rt = rt; i_con_start = 1'b1;
    tick;
    i_con_start = 1'b0;
    lat = 1;
    while (!o_con_done && lat < 60) begin
      if (o_con_busy !== 1'b1) busy_bad++;
      tick;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), edz ? 64'd1 : 64'd34);
    chk({nm, " busy_in_flight"}, 64'(busy_bad), 64'd0);
    chk({nm, " busy_in_done"}, {63'd0, o_con_busy}, 64'd0);
    chk({nm, " divzero"}, {63'd0, o_con_divzero}, {63'd0, edz});
    chk({nm, " hi"}, {32'd0, o_data_hi}, {32'd0, ehi});
    chk({nm, " lo"}, {32'd0, o_data_lo}, {32'd0, elo});
    if (restart) i_con_start = 1'b1;
    tick;
    i_con_start = 1'b0;
    chk({nm, " done_one_cycle"}, {63'd0, o_con_done}, 64'd0);
    if (restart) chk({nm, " start_in_done_dropped"}, {63'd0, o_con_busy}, 64'd0);
    sh_hi = ehi; sh_lo = elo;
  endtask

  initial begin
    logic [31:0] ehi, elo, rs, rt;
    logic [1:0] op;
    bit dz;
    int bad;

    vecs[0] = '{2'b00, 32'd7, 32'd6, 32'h0, 32'h2A, 32'h0, 32'h2A};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 32'h40000000, 32'h0};
    vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC, 32'h1, 32'h7FFFFFFC};
    vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'h80000000};
    vecs[6] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 32'h1};
    vecs[7] = '{2'b10, 32'd100, 32'd7, 32'd2, 32'h0E, 32'd2, 32'h0E};
    vecs[8] = '{2'b11, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 32'd1, 32'hFFFFFFFD};
    vecs[9] = '{2'b10, 32'd3, 32'd5, 32'd3, 32'd0, 32'd3, 32'd0};

    tick; tick;
    i_rst = 1'b0;
    tick;
    chk("reset hi", {32'd0, o_data_hi}, 64'd0);
    chk("reset lo", {32'd0, o_data_lo}, 64'd0);
    chk("reset busy", {63'd0, o_con_busy}, 64'd0);
    chk("reset done", {63'd0, o_con_done}, 64'd0);
    chk("reset divzero", {63'd0, o_con_divzero}, 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             SIGNED ? vecs[i].hi_s : vecs[i].hi_u, SIGNED ? vecs[i].lo_s : vecs[i].lo_u,
             1'b0, i == 0);

    // divide by zero with HI=0x11 LO=0x22 preset
    run_op("preset", 2'b10, 32'h2211, 32'h100, 32'h11, 32'h22, 1'b0, 1'b0);
    run_op("divzero", 2'b10, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0);

    // flush at cycle 10, relaunch at cycle 12
    i_con_mdop = 2'b00; i_data_rs = 32'd9; i_data_rt = 32'd9; i_con_start = 1'b1;
    tick; i_con_start = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    i_con_flush = 1'b1;
    tick; i_con_flush = 1'b0;
    chk("flush busy", {63'd0, o_con_busy}, 64'd0);
    chk("flush done", {63'd0, o_con_done}, 64'd0);
    tick;
    chk("flush hi", {32'd0, o_data_hi}, {32'd0, sh_hi});
    chk("flush lo", {32'd0, o_data_lo}, {32'd0, sh_lo});
    run_op("after_flush", 2'b00, 32'd12, 32'd12, 32'd0, 32'd144, 1'b0, 1'b0);

    // flush during FIX (cycle 33) must suppress the write and the done pulse
    i_con_mdop = 2'b00; i_data_rs = 32'hFFFF; i_data_rt = 32'hFFFF; i_con_start = 1'b1;
    tick; i_con_start = 1'b0;
    for (int c = 1; c < 33; c++) tick;
    i_con_flush = 1'b1;
    tick; i_con_flush = 1'b0;
    chk("fixflush done", {63'd0, o_con_done}, 64'd0);
    chk("fixflush lo", {32'd0, o_data_lo}, {32'd0, sh_lo});

    // stall with hiloread held from cycle 5
    bad = 0;
    i_con_mdop = 2'b00; i_data_rs = 32'd3; i_data_rt = 32'd5; i_con_start = 1'b1;
    tick; i_con_start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c >= 5) i_con_hiloread = 1'b1;
      #1;
      if (o_con_stall !== ((c >= 5 && c <= 33) ? 1'b1 : 1'b0)) bad++;
      if (c < 34) tick;
    end
    chk("stall window", 64'(bad), 64'd0);
    chk("stall done", {63'd0, o_con_done}, 64'd1);
    i_con_hiloread = 1'b0;
    tick;
    sh_hi = 32'd0; sh_lo = 32'd15;

    // reset pulse at cycle 20 aborts an operation
    i_con_mdop = 2'b00; i_data_rs = 32'd1000; i_data_rt = 32'd1000; i_con_start = 1'b1;
    tick; i_con_start = 1'b0;
    for (int c = 1; c < 20; c++) tick;
    i_rst = 1'b1; #1;
    chk("rst busy", {63'd0, o_con_busy}, 64'd0);
    chk("rst hi", {32'd0, o_data_hi}, 64'd0);
    chk("rst lo", {32'd0, o_data_lo}, 64'd0);
    tick; i_rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_con_done !== 1'b0 || o_data_lo !== 32'd0) bad++;
      tick;
    end
    chk("rst no_write", 64'(bad), 64'd0);
    sh_hi = 32'd0; sh_lo = 32'd0;
    run_op("after_rst", 2'b00, 32'd7, 32'd6, 32'd0, 32'h2A, 1'b0, 1'b0);

    // randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rs = 32'h80000000;
        1: rs = 32'($urandom_range(0, 255));
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: rt = 32'hFFFFFFFF;
        2: rt = 32'($urandom_range(1, 16));
        default: rt = $urandom;
      endcase
      model(op, rs, rt, ehi, elo, dz);
      run_op($sformatf("rand%0d", n), op, rs, rt, ehi, elo, dz, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
